// File: rtl/count_sequencer.sv
// count_sequencer: drives an external CW-bit toggle counter through a number
// of clear-then-count passes, stopping each pass exactly at a latched terminal
// value. Reports progress (pass_cnt), completion (done) and failures (err).
module count_sequencer #(
  parameter int CW = 4,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] term,
  input  logic [PW-1:0] passes,
  input  logic          abort,
  input  logic [CW-1:0] cnt_q,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] pass_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] term_q, term_d;
  logic [PW-1:0] passes_q, passes_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic          err_q, err_d;

  // State and latched command registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      term_q     <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state and counter-control decode; abort outranks terminal and fault.
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((passes != '0) && (term != '0)) begin
            term_d     = term;
            passes_d   = passes;
            pass_cnt_d = '0;
            state_d    = CLEAR;
          end else begin
            // Degenerate command: flag it, keep the previous pass count.
            err_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        busy    = 1'b1;
        cnt_clr = 1'b1;
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q > term_q) begin
          // Counter ran past the terminal value: it is not following cnt_en.
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == term_q) begin
          pass_cnt_d = pass_cnt_q + PW'(1);
          state_d    = (pass_cnt_d == passes_q) ? DONE : CLEAR;
        end else begin
          cnt_en = 1'b1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err      = err_q;
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: an external counter model, directed scenarios
// with literal expectations, and randomized traffic compared every cycle
// against a schedule-based model of a sequence.
module tb_count_sequencer;

  localparam int CW = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] term;
  logic [PW-1:0] passes;
  logic          abort;
  logic [CW-1:0] cnt_q;
  logic          cnt_en;
  logic          cnt_clr;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] pass_cnt;

  // Counter under control, with an override for fault injection.
  logic [CW-1:0] cnt_r = '0;
  logic          force_en = 1'b0;
  logic [CW-1:0] force_val = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  // Per-cycle recordings for directed scenarios.
  logic [31:0] bv, cv, ev, dv, rv;

  // Sequence model: position within the accepted sequence (0 = not running).
  int m_pos = 0;
  int m_term = 0;
  int m_passes = 0;
  int m_pcnt = 0;
  bit m_err = 1'b0;

  count_sequencer #(.CW(CW), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .term     (term),
    .passes   (passes),
    .abort    (abort),
    .cnt_q    (cnt_q),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_clr) cnt_r <= '0;
    else if (cnt_en) cnt_r <= cnt_r + 1'b1;
  end

  assign cnt_q = force_en ? force_val : cnt_r;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    int L, total, off, e_pc;
    bit e_busy, e_clr, e_en, e_done;
    e_busy = 0; e_clr = 0; e_en = 0; e_done = 0; e_pc = m_pcnt;
    L = m_term + 2;
    total = m_passes * L;
    off = 0;
    if (m_pos > 0) begin
      if (m_pos <= total) begin
        off    = (m_pos - 1) % L;
        e_busy = 1;
        e_clr  = (off == 0);
        e_en   = (off != 0) && !abort && (int'(cnt_q) < m_term);
        e_pc   = (m_pos - 1) / L;
      end else begin
        e_done = 1;
        e_pc   = m_passes;
      end
    end
    if (chk_on) begin
      chk("busy", int'(busy), int'(e_busy));
      chk("cnt_clr", int'(cnt_clr), int'(e_clr));
      chk("cnt_en", int'(cnt_en), int'(e_en));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(m_err));
      chk("pass_cnt", int'(pass_cnt), e_pc);
    end
    if (rst) begin
      m_pos = 0; m_pcnt = 0; m_err = 0;
    end else if (m_pos == 0) begin
      m_err = start && (passes == 0 || term == 0);
      if (start && passes != 0 && term != 0) begin
        m_term = int'(term); m_passes = int'(passes); m_pos = 1; m_pcnt = 0;
      end
    end else begin
      m_err = 0;
      if (m_pos <= total) begin
        if (abort || (off != 0 && int'(cnt_q) > m_term)) begin
          m_err = 1; m_pcnt = e_pc; m_pos = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_pcnt = m_passes; m_pos = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int k);
    bv[k] = busy; cv[k] = cnt_clr; ev[k] = cnt_en; dv[k] = done; rv[k] = err;
  endtask

  // Start pulse in cycle 0, then record cycles 0..n.
  task automatic run_seq(input int t, input int p, input int n, input bit hold);
    bv = '0; cv = '0; ev = '0; dv = '0; rv = '0;
    tick();
    start = 1'b1; term = CW'(t); passes = PW'(p);
    #1; rec(0);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1 && !hold) start = 1'b0;
      #1; rec(k);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; term = '0; passes = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pass_cnt", int'(pass_cnt), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // term=3, passes=2
    run_seq(3, 2, 12, 1'b0);
    chk("d1_busy_vec", int'(bv), 32'h7FE);
    chk("d1_clr_vec", int'(cv), 32'h042);
    chk("d1_en_vec", int'(ev), 32'h39C);
    chk("d1_done_vec", int'(dv), 32'h800);
    chk("d1_err_vec", int'(rv), 0);
    chk("d1_pass_cnt", int'(pass_cnt), 2);

    // Rejected commands
    tick(); start = 1'b1; term = 4'd3; passes = 3'd0;
    tick(); start = 1'b0; #1;
    chk("d2a_err", int'(err), 1);
    chk("d2a_busy", int'(busy), 0);
    chk("d2a_pass_cnt", int'(pass_cnt), 2);
    tick(); chk("d2a_err_clear", int'(err), 0);
    tick(); start = 1'b1; term = 4'd0; passes = 3'd2;
    tick(); start = 1'b0; #1;
    chk("d2b_err", int'(err), 1);
    chk("d2b_busy", int'(busy), 0);
    chk("d2b_pass_cnt", int'(pass_cnt), 2);
    tick(); chk("d2b_err_clear", int'(err), 0);

    // Full-range count
    run_seq(15, 1, 19, 1'b0);
    chk("d3_done_vec", int'(dv), 32'h0004_0000);
    chk("d3_busy_vec", int'(bv), 32'h0003_FFFE);
    chk("d3_cnt_hold", int'(cnt_q), 15);
    chk("d3_pass_cnt", int'(pass_cnt), 1);

    // Abort in RUN at cnt_q=2
    tick(); start = 1'b1; term = 4'd5; passes = 3'd1;
    tick(); start = 1'b0;
    tick();
    tick();
    tick(); abort = 1'b1; #1;
    chk("d4_cnt_q", int'(cnt_q), 2);
    chk("d4_en_abort", int'(cnt_en), 0);
    chk("d4_busy", int'(busy), 1);
    tick(); abort = 1'b0; #1;
    chk("d4_err", int'(err), 1);
    chk("d4_busy_after", int'(busy), 0);
    chk("d4_done", int'(done), 0);
    tick();
    chk("d4_done2", int'(done), 0);
    run_seq(1, 1, 5, 1'b0);
    chk("d4_restart_done_vec", int'(dv), 32'h10);
    chk("d4_restart_busy_vec", int'(bv), 32'hE);
    chk("d4_restart_pass_cnt", int'(pass_cnt), 1);

    // Counter fault
    tick(); start = 1'b1; term = 4'd3; passes = 3'd1;
    tick(); start = 1'b0;
    tick();
    tick(); force_en = 1'b1; force_val = 4'd4; #1;
    chk("d5_en_fault", int'(cnt_en), 0);
    chk("d5_busy", int'(busy), 1);
    tick(); force_en = 1'b0; #1;
    chk("d5_err", int'(err), 1);
    chk("d5_busy_after", int'(busy), 0);
    tick();
    chk("d5_err_clear", int'(err), 0);

    // Reset mid-sequence
    tick(); start = 1'b1; term = 4'd4; passes = 3'd3;
    tick(); start = 1'b0;
    repeat (7) tick();
    chk("d6_pass_cnt_mid", int'(pass_cnt), 1);
    chk("d6_busy_mid", int'(busy), 1);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("d6_busy", int'(busy), 0);
    chk("d6_pass_cnt", int'(pass_cnt), 0);
    chk("d6_done", int'(done), 0);
    chk("d6_err", int'(err), 0);

    // start held high
    run_seq(1, 1, 7, 1'b1);
    chk("d7_busy_vec", int'(bv), 32'hCE);
    chk("d7_done_vec", int'(dv), 32'h10);
    start = 1'b0;
    repeat (8) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst    = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 3) == 0);
      term   = CW'($urandom_range(0, 6));
      passes = PW'($urandom_range(0, 3));
      abort  = ($urandom_range(0, 39) == 0);
    end
    tick();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
